array_scan_correlator: RTL and testbench

Parametrised multi-element successor to the single-pair coincidence sampler. Steps the receive multiplexer through a ROWS×COLS transducer grid, waits a settle interval after each select change, measures the coincidence count between the reference and selected comparator bitstreams over a bounded window, and writes each result into an internal result memory. The memory has a registered read port for the display path. The block sits in the pwm_clk domain, between the comparator inputs and the TFT display logic.

---
 rtl/array_scan_correlator_pkg.sv | 23 ++
 rtl/array_scan_correlator_coincidence_window.sv | 53 +++++
 rtl/array_scan_correlator.sv | 173 +++++++++++++++++
 tb/tb_array_scan_correlator.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/array_scan_correlator_pkg.sv
// Shared types and default constants for the array scan correlator.
package array_scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        ACCUM,
        STORE
    } scan_state_e;

    localparam int DEF_ROWS          = 7;
    localparam int DEF_COLS          = 7;
    localparam int DEF_CNT_W         = 16;
    localparam int DEF_MAX_CYCLES    = 16384;
    localparam int DEF_HIGH_CYCLES   = 4096;
    localparam int DEF_SETTLE_CYCLES = 64;
    localparam int DEF_AVG_SHIFT     = 2;

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/array_scan_correlator_coincidence_window.sv
// Bounded coincidence window: counts cycles, reference highs, selected highs
// and coincidences; done flags the terminating cycle (its sample is included).
module coincidence_window #(
    parameter int CNT_W       = 16,
    parameter int MAX_CYCLES  = 16384,
    parameter int HIGH_CYCLES = 4096
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             run_i,
    input  logic             ref_i,
    input  logic             sel_i,
    output logic             done_o,
    output logic [CNT_W-1:0] m_o
);

    logic [CNT_W-1:0] cyc_q, a_q, b_q, m_q;
    logic [CNT_W-1:0] cyc_d, a_d, b_d, m_d;

    always_comb begin
        cyc_d = cyc_q + CNT_W'(1);
        a_d   = a_q + CNT_W'(ref_i);
        b_d   = b_q + CNT_W'(sel_i);
        m_d   = m_q + CNT_W'(ref_i & sel_i);
    end

    // Compare against next values so the terminating sample is counted.
    assign done_o = run_i && ((cyc_d == CNT_W'(MAX_CYCLES)) ||
                              (a_d == CNT_W'(HIGH_CYCLES)) ||
                              (b_d == CNT_W'(HIGH_CYCLES)));
    assign m_o = m_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cyc_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            m_q   <= '0;
        end else if (clear_i) begin
            cyc_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            m_q   <= '0;
        end else if (run_i) begin
            cyc_q <= cyc_d;
            a_q   <= a_d;
            b_q   <= b_d;
            m_q   <= m_d;
        end
    end

endmodule

// File: rtl/array_scan_correlator.sv
// Grid-scanning coincidence correlator with result memory and registered read port.
// Optional smoothing of stored results when ARRAY_SCAN_AVG_EN is defined.
module array_scan_correlator
    import array_scan_pkg::*;
#(
    parameter int ROWS          = DEF_ROWS,
    parameter int COLS          = DEF_COLS,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int MAX_CYCLES    = DEF_MAX_CYCLES,
    parameter int HIGH_CYCLES   = DEF_HIGH_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int AVG_SHIFT     = DEF_AVG_SHIFT,
    localparam int RW = clog2_min1(ROWS),
    localparam int CW = clog2_min1(COLS),
    localparam int AW = clog2_min1(ROWS * COLS)
) (
    input  logic             pwm_clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             in_ref,
    input  logic             in_sel,
    output logic [RW-1:0]    row,
    output logic [CW-1:0]    col,
    output logic             busy,
    output logic             sample_valid,
    output logic [CNT_W-1:0] sample_count,
    output logic             frame_done,
    output logic             frame_valid,
    input  logic [AW-1:0]    rd_addr,
    output logic [CNT_W-1:0] rd_data
);

    localparam int DEPTH = ROWS * COLS;
    localparam int SW    = clog2_min1(SETTLE_CYCLES);
`ifdef ARRAY_SCAN_AVG_EN
    localparam bit AVG_ON = 1'b1;
`else
    localparam bit AVG_ON = 1'b0;
`endif

    scan_state_e      state_q;
    logic [SW-1:0]    settle_q;
    logic [RW-1:0]    row_q;
    logic [CW-1:0]    col_q;
    logic             busy_q, sample_valid_q, frame_done_q, frame_valid_q;
    logic [CNT_W-1:0] sample_count_q, rd_data_q;
    logic [CNT_W-1:0] mem_q [DEPTH];

    logic             win_clear, win_run, win_done;
    logic [CNT_W-1:0] win_m, store_val;
    logic [AW-1:0]    wr_addr;
    logic             settle_last;

    assign settle_last = (settle_q == SW'(SETTLE_CYCLES - 1));
    assign win_clear   = (state_q == SETTLE) && settle_last;
    assign win_run     = (state_q == ACCUM);
    assign wr_addr     = AW'(int'(row_q) * COLS + int'(col_q));

    coincidence_window #(
        .CNT_W       (CNT_W),
        .MAX_CYCLES  (MAX_CYCLES),
        .HIGH_CYCLES (HIGH_CYCLES)
    ) u_window (
        .clk_i   (pwm_clk),
        .rst_ni  (rst_n),
        .clear_i (win_clear),
        .run_i   (win_run),
        .ref_i   (in_ref),
        .sel_i   (in_sel),
        .done_o  (win_done),
        .m_o     (win_m)
    );

    // Smoothing reads the old entry combinationally so STORE stays one cycle;
    // raw values are stored until a full frame exists.
    logic signed [CNT_W:0] old_s, diff_s, avg_s;
    always_comb begin
        old_s     = $signed({1'b0, mem_q[wr_addr]});
        diff_s    = $signed({1'b0, win_m}) - old_s;
        avg_s     = old_s + (diff_s >>> AVG_SHIFT);
        store_val = (AVG_ON && frame_valid_q) ? avg_s[CNT_W-1:0] : win_m;
    end

    always_ff @(posedge pwm_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            settle_q       <= '0;
            row_q          <= '0;
            col_q          <= '0;
            busy_q         <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_count_q <= '0;
            frame_done_q   <= 1'b0;
            frame_valid_q  <= 1'b0;
        end else begin
            sample_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q  <= SETTLE;
                        settle_q <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (settle_last) begin
                        state_q <= ACCUM;
                    end else begin
                        settle_q <= settle_q + SW'(1);
                    end
                end
                ACCUM: begin
                    if (win_done) begin
                        state_q <= STORE;
                    end
                end
                STORE: begin
                    sample_count_q <= store_val;
                    sample_valid_q <= 1'b1;
                    if (col_q == CW'(COLS - 1)) begin
                        col_q <= '0;
                        if (row_q == RW'(ROWS - 1)) begin
                            row_q         <= '0;
                            frame_done_q  <= 1'b1;
                            frame_valid_q <= 1'b1;
                        end else begin
                            row_q <= row_q + RW'(1);
                        end
                    end else begin
                        col_q <= col_q + CW'(1);
                    end
                    settle_q <= '0;
                    if (enable) begin
                        state_q <= SETTLE;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge pwm_clk) begin
        if (state_q == STORE) begin
            mem_q[wr_addr] <= store_val;
        end
    end

    always_ff @(posedge pwm_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign row          = row_q;
    assign col          = col_q;
    assign busy         = busy_q;
    assign sample_valid = sample_valid_q;
    assign sample_count = sample_count_q;
    assign frame_done   = frame_done_q;
    assign frame_valid  = frame_valid_q;
    assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_array_scan_correlator.sv
// Directed bench for array_scan_correlator on a 2x3 grid with short windows;
// expected stored values also cover the ARRAY_SCAN_AVG_EN build.
module tb_array_scan_correlator;

    localparam int ROWS = 2;
    localparam int COLS = 3;
    localparam int CNT_W = 8;

`ifdef ARRAY_SCAN_AVG_EN
    localparam int EXP_ONE_ZERO = 6;
    localparam int EXP_ZERO     = 6;
    localparam int EXP_TOGGLE   = 7;
`else
    localparam int EXP_ONE_ZERO = 0;
    localparam int EXP_ZERO     = 0;
    localparam int EXP_TOGGLE   = 4;
`endif

    logic             pwm_clk;
    logic             rst_n;
    logic             enable;
    logic             in_ref;
    logic             in_sel;
    logic [0:0]       row;
    logic [1:0]       col;
    logic             busy;
    logic             sample_valid;
    logic [CNT_W-1:0] sample_count;
    logic             frame_done;
    logic             frame_valid;
    logic [2:0]       rd_addr;
    logic [CNT_W-1:0] rd_data;

    int n_vec = 0;
    int n_err = 0;
    int tcnt = 0;
    int base = 0;
    int at = 0;
    bit toggle_en = 1'b0;
    int exp_mem [6];

    array_scan_correlator #(
        .ROWS          (ROWS),
        .COLS          (COLS),
        .CNT_W         (CNT_W),
        .MAX_CYCLES    (32),
        .HIGH_CYCLES   (8),
        .SETTLE_CYCLES (4),
        .AVG_SHIFT     (2)
    ) dut (
        .pwm_clk      (pwm_clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .in_ref       (in_ref),
        .in_sel       (in_sel),
        .row          (row),
        .col          (col),
        .busy         (busy),
        .sample_valid (sample_valid),
        .sample_count (sample_count),
        .frame_done   (frame_done),
        .frame_valid  (frame_valid),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data)
    );

    initial pwm_clk = 1'b0;
    always #5 pwm_clk = ~pwm_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge pwm_clk);
        if (toggle_en) in_ref = ~in_ref;
        tcnt++;
    endtask

    task automatic wait_valid(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            tick();
            if (sample_valid === 1'b1) break;
        end
        at = tcnt - base;
        check("sample_valid_seen", {31'd0, sample_valid}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; in_ref = 1'b0; in_sel = 1'b0; rd_addr = '0;
        repeat (3) @(negedge pwm_clk);
        check("rst_row", row, 0);
        check("rst_col", col, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_count", sample_count, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_valid", frame_valid, 0);
        check("rst_rd_data", rd_data, 0);

        // Frame 1: constant ones, every element stores 8, 13-cycle period.
        rst_n = 1'b1;
        tick();
        in_ref = 1'b1; in_sel = 1'b1; enable = 1'b1;
        tick();
        base = tcnt;
        check("busy_after_idle", busy, 1);
        for (int k = 0; k < 6; k++) begin
            wait_valid(40);
            check("f1_time", at, 13 * (k + 1));
            check("f1_count", sample_count, 8);
            check("f1_next_row", row, ((k + 1) % 6) / 3);
            check("f1_next_col", col, (k + 1) % 3);
            check("f1_frame_done", frame_done, (k == 5) ? 1 : 0);
            check("f1_frame_valid", frame_valid, (k == 5) ? 1 : 0);
        end

        // Element (0,0): ref only -> HIGH on a, no coincidences.
        in_sel = 1'b0;
        wait_valid(40);
        check("ref_only_time", at, 91);
        check("ref_only_count", sample_count, EXP_ONE_ZERO);

        // Element (0,1): all zero -> runs to MAX_CYCLES.
        in_ref = 1'b0;
        wait_valid(60);
        check("zero_time", at, 128);
        check("zero_count", sample_count, EXP_ZERO);

        // Element (0,2): toggling ref, sel high; enable dropped mid-ACCUM.
        in_sel = 1'b1;
        toggle_en = 1'b1;
        repeat (6) tick();
        enable = 1'b0;
        wait_valid(40);
        check("toggle_time", at, 141);
        check("toggle_count", sample_count, EXP_TOGGLE);
        check("stop_busy", busy, 0);
        check("stop_row", row, 1);
        check("stop_col", col, 0);
        repeat (5) tick();
        check("idle_busy", busy, 0);
        check("idle_valid", sample_valid, 0);
        check("idle_row", row, 1);
        check("idle_col", col, 0);

        // Resume: single element at address 3.
        enable = 1'b1;
        tick();
        base = tcnt;
        enable = 1'b0;
        check("resume_busy", busy, 1);
        wait_valid(40);
        check("resume_time", at, 13);
        check("resume_count", sample_count, EXP_TOGGLE);
        check("resume_row", row, 1);
        check("resume_col", col, 1);
        check("resume_idle", busy, 0);

        // Asynchronous reset during ACCUM of element (1,1).
        toggle_en = 1'b0;
        in_ref = 1'b1; in_sel = 1'b1; enable = 1'b1;
        repeat (7) tick();
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("arst_row", row, 0);
        check("arst_col", col, 0);
        check("arst_busy", busy, 0);
        check("arst_valid", sample_valid, 0);
        check("arst_count", sample_count, 0);
        check("arst_frame_valid", frame_valid, 0);
        check("arst_rd_data", rd_data, 0);
        tick();
        rst_n = 1'b1;
        tick();
        base = tcnt;
        enable = 1'b0;
        wait_valid(40);
        check("restart_time", at, 13);
        check("restart_count", sample_count, 8);
        check("restart_row", row, 0);
        check("restart_col", col, 1);
        check("restart_frame_valid", frame_valid, 0);

        // Read back the result memory through the registered port.
        exp_mem[0] = 8;
        exp_mem[1] = EXP_ZERO;
        exp_mem[2] = EXP_TOGGLE;
        exp_mem[3] = EXP_TOGGLE;
        exp_mem[4] = 8;
        exp_mem[5] = 8;
        tick();
        for (int a = 0; a < 6; a++) begin
            rd_addr = 3'(a);
            tick();
            check("mem_read", rd_data, exp_mem[a]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
